diff_pair_checker: RTL

Sampling stage placed directly downstream of the differential input buffer. It takes the buffer's true/complement outputs (O/OB) into the CLK domain and checks that the pair stays complementary. Data is passed on only while the pair is valid, and a sustained invalid pair is flagged as a fault. It also produces registered data, edge pulses, valid/fault status and a saturating fault-event counter for the fabric logic that follows.

---
 rtl/diff_pair_checker_if.sv | 25 ++
 rtl/diff_pair_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/diff_pair_checker_if.sv
// Bundles the differential-pair inputs and the checker's status outputs.
// The master modport drives the pair; the slave modport is the checker.
interface diff_pair_checker_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 i_p;
    logic                 i_n;
    logic                 clr_err;
    logic                 dout;
    logic                 rise;
    logic                 fall;
    logic                 valid;
    logic                 fault;
    logic [CNT_WIDTH-1:0] err_cnt;

    modport master (
        output i_p, i_n, clr_err,
        input  dout, rise, fall, valid, fault, err_cnt
    );

    modport slave (
        input  i_p, i_n, clr_err,
        output dout, rise, fall, valid, fault, err_cnt
    );
endinterface

// File: rtl/diff_pair_checker.sv
// Synchronizes a differential pair, checks that it stays complementary and tracks faults.
// Define PAIR_CHK_ERR_CNT_EN to build the saturating fault-entry counter and its clear.
module diff_pair_checker #(
    parameter int FAULT_LIMIT   = 4,
    parameter int RECOVER_LIMIT = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_WIDTH     = 8
) (
    input logic                clk_i,
    input logic                rstn_i,
    diff_pair_checker_if.slave pair
);
    localparam logic [7:0] FaultLim   = 8'(FAULT_LIMIT);
    localparam logic [7:0] RecoverLim = 8'(RECOVER_LIMIT);

    typedef enum logic [2:0] {INIT, OK, SUSPECT, FAULTED, RECOVER} state_t;

    logic [SYNC_STAGES-1:0] syncP_q;
    logic [SYNC_STAGES-1:0] syncN_q;
    state_t                 state_q, state_d;
    logic [7:0]             run_q, run_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   valid_q;
    logic                   fault_q;
    logic                   faultEntry_d;
    logic                   sp;
    logic                   sn;
    logic                   good;

    assign sp   = syncP_q[SYNC_STAGES-1];
    assign sn   = syncN_q[SYNC_STAGES-1];
    assign good = sp ^ sn;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            syncP_q <= '0;
            syncN_q <= '0;
        end else begin
            syncP_q <= {syncP_q[SYNC_STAGES-2:0], pair.i_p};
            syncN_q <= {syncN_q[SYNC_STAGES-2:0], pair.i_n};
        end
    end

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        dout_d       = dout_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        faultEntry_d = 1'b0;
        case (state_q)
            INIT: begin
                if (good) begin
                    state_d = OK;
                    dout_d  = sp;
                end
            end
            OK, SUSPECT: begin
                if (good) begin
                    state_d = OK;
                    run_d   = 8'd0;
                    dout_d  = sp;
                    rise_d  = sp & ~dout_q;
                    fall_d  = ~sp & dout_q;
                end else if (state_q == OK && FaultLim != 8'd1) begin
                    state_d = SUSPECT;
                    run_d   = 8'd1;
                end else if (state_q == SUSPECT && (run_q + 8'd1) != FaultLim) begin
                    run_d = run_q + 8'd1;
                end else begin
                    state_d      = FAULTED;
                    run_d        = 8'd0;
                    faultEntry_d = 1'b1;
                end
            end
            FAULTED: begin
                if (good && RecoverLim == 8'd1) begin
                    state_d = OK;
                    run_d   = 8'd0;
                    dout_d  = sp;
                end else if (good) begin
                    state_d = RECOVER;
                    run_d   = 8'd1;
                end
            end
            RECOVER: begin
                if (!good) begin
                    state_d      = FAULTED;
                    run_d        = 8'd0;
                    faultEntry_d = 1'b1;
                end else if ((run_q + 8'd1) == RecoverLim) begin
                    state_d = OK;
                    run_d   = 8'd0;
                    dout_d  = sp;
                end else begin
                    run_d = run_q + 8'd1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Status flags are decoded from the next state so they line up with DOUT.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= INIT;
            run_q   <= 8'd0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            valid_q <= (state_d == OK) || (state_d == SUSPECT);
            fault_q <= (state_d == FAULTED) || (state_d == RECOVER);
        end
    end

    assign pair.dout  = dout_q;
    assign pair.rise  = rise_q;
    assign pair.fall  = fall_q;
    assign pair.valid = valid_q;
    assign pair.fault = fault_q;

`ifdef PAIR_CHK_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] errCnt_q;

    // Clear has priority over a coincident fault entry; the count sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            errCnt_q <= '0;
        end else if (pair.clr_err) begin
            errCnt_q <= '0;
        end else if (faultEntry_d && errCnt_q != '1) begin
            errCnt_q <= errCnt_q + CNT_WIDTH'(1);
        end
    end

    assign pair.err_cnt = errCnt_q;
`else
    logic unusedCounterInputs;
    assign unusedCounterInputs = pair.clr_err ^ faultEntry_d;
    assign pair.err_cnt        = '0;
`endif
endmodule
